// File: rtl/vram_pkg.sv
// vram_pkg
//   Shared constants and types for the VRAM fill controller.
//   SCREEN_W / SCREEN_H : frame geometry (160 x 120)
//   POS_W               : linear pixel address width
//   COLOUR_W            : 12-bit colour, 4 bits per channel
package vram_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int POS_W    = 16;
    localparam int COLOUR_W = 12;

    typedef logic [POS_W-1:0]    pos_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // y*160 without a multiplier: 160 = 128 + 32
    function automatic pos_t row_base_of(input logic [6:0] y);
        return (pos_t'(y) << 7) + (pos_t'(y) << 5);
    endfunction

endpackage

// File: rtl/vram_fill_ctrl_rect_walker.sv
// rect_walker
//   Holds the clipped rectangle bounds and walks it in row-major order.
//   Ports:
//     clk, reset            : clock, async active-high reset
//     load                  : capture cmd_* and start at the top-left corner
//     step                  : advance to the next pixel
//     cmd_x/y/w/h           : raw command geometry (only sampled on load)
//     pos                   : linear address of the current pixel
//     last                  : current pixel is the final one of the rectangle
//     empty                 : raw command geometry describes no pixels
module rect_walker
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [6:0] cmd_h,
    output pos_t       pos,
    output logic       last,
    output logic       empty
);

    logic [7:0] cur_x_q, cur_x_d;
    logic [7:0] x_start_q, x_start_d;
    logic [8:0] x_end_q, x_end_d;
    logic [6:0] cur_y_q, cur_y_d;
    logic [7:0] y_end_q, y_end_d;
    pos_t       row_base_q, row_base_d;

    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       x_wrap;
    logic       y_last;

    // Clip arithmetic and end-of-row / end-of-rect detection
    always_comb begin
        // sums are one bit wider than the operands so they cannot wrap
        sum_x  = {1'b0, cmd_x} + {1'b0, cmd_w};
        sum_y  = {1'b0, cmd_y} + {1'b0, cmd_h};
        empty  = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                 ({1'b0, cmd_x} >= 9'(SCREEN_W)) ||
                 ({1'b0, cmd_y} >= 8'(SCREEN_H));
        x_wrap = (({1'b0, cur_x_q} + 9'd1) == x_end_q);
        y_last = (({1'b0, cur_y_q} + 8'd1) == y_end_q);
        last   = x_wrap && y_last;
        pos    = row_base_q + pos_t'(cur_x_q);
    end

    // Next-state for the walk counters
    always_comb begin
        cur_x_d    = cur_x_q;
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        cur_y_d    = cur_y_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        if (load) begin
            cur_x_d    = cmd_x;
            x_start_d  = cmd_x;
            x_end_d    = (sum_x > 9'(SCREEN_W)) ? 9'(SCREEN_W) : sum_x;
            cur_y_d    = cmd_y;
            y_end_d    = (sum_y > 8'(SCREEN_H)) ? 8'(SCREEN_H) : sum_y;
            row_base_d = row_base_of(cmd_y);
        end else if (step) begin
            if (x_wrap) begin
                cur_x_d    = x_start_q;
                cur_y_d    = cur_y_q + 7'd1;
                row_base_d = row_base_q + pos_t'(SCREEN_W);
            end else begin
                cur_x_d    = cur_x_q + 8'd1;
            end
        end else begin
            cur_x_d    = cur_x_q;
        end
    end

    // Walk counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x_q    <= 8'd0;
            x_start_q  <= 8'd0;
            x_end_q    <= 9'd0;
            cur_y_q    <= 7'd0;
            y_end_q    <= 8'd0;
            row_base_q <= '0;
        end else begin
            cur_x_q    <= cur_x_d;
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            cur_y_q    <= cur_y_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl
//   Sole driver of the VRAM write port. Walks rectangle-fill commands one
//   pixel per cycle and merges a CPU plot port that always wins.
//   Ports:
//     clk, reset                          : clock, async active-high reset
//     cmd_valid / cmd_ready               : fill command handshake
//     cmd_x, cmd_y, cmd_w, cmd_h          : rectangle geometry
//     cmd_colour                          : fill colour
//     cpu_plot, cpu_pos, cpu_colour       : CPU single-pixel write
//     plot, buf_pos, colour               : registered VRAM write port
//     busy                                : command in progress (FILL/DONE)
//     done                                : one-cycle completion pulse
module vram_fill_ctrl
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [6:0] cmd_h,
    input  colour_t    cmd_colour,
    input  logic       cpu_plot,
    input  pos_t       cpu_pos,
    input  colour_t    cpu_colour,
    output logic       plot,
    output pos_t       buf_pos,
    output colour_t    colour,
    output logic       busy,
    output logic       done
);

    fill_state_t state_q, state_d;
    colour_t     fill_colour_q, fill_colour_d;
    logic        plot_q, plot_d;
    pos_t        buf_pos_q, buf_pos_d;
    colour_t     colour_q, colour_d;

    logic        load;
    logic        step;
    pos_t        walk_pos;
    logic        walk_last;
    logic        walk_empty;

    rect_walker u_walker (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .cmd_x (cmd_x),
        .cmd_y (cmd_y),
        .cmd_w (cmd_w),
        .cmd_h (cmd_h),
        .pos   (walk_pos),
        .last  (walk_last),
        .empty (walk_empty)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: empty commands skip straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = walk_empty ? DONE : FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                // a CPU-stolen cycle never retires the last pixel
                if (!cpu_plot && walk_last) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            FILL: begin
                busy      = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
            end
            default: begin
                busy      = 1'b1;
            end
        endcase
    end

    // Accept/advance strobes and the CPU-priority write mux
    always_comb begin
        load          = (state_q == IDLE) && cmd_valid;
        step          = (state_q == FILL) && !cpu_plot;
        fill_colour_d = load ? cmd_colour : fill_colour_q;
        plot_d        = cpu_plot || step;
        if (cpu_plot) begin
            buf_pos_d = cpu_pos;
            colour_d  = cpu_colour;
        end else if (step) begin
            buf_pos_d = walk_pos;
            colour_d  = fill_colour_q;
        end else begin
            buf_pos_d = buf_pos_q;
            colour_d  = colour_q;
        end
    end

    // Output and latched-colour registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_colour_q <= '0;
            plot_q        <= 1'b0;
            buf_pos_q     <= '0;
            colour_q      <= '0;
        end else begin
            fill_colour_q <= fill_colour_d;
            plot_q        <= plot_d;
            buf_pos_q     <= buf_pos_d;
            colour_q      <= colour_d;
        end
    end

    assign plot    = plot_q;
    assign buf_pos = buf_pos_q;
    assign colour  = colour_q;

endmodule

// File: tb/tb_vram_fill_ctrl.sv
module tb_vram_fill_ctrl;
    import vram_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    colour_t    cmd_colour;
    logic       cpu_plot;
    pos_t       cpu_pos;
    colour_t    cpu_colour;
    logic       plot;
    pos_t       buf_pos;
    colour_t    colour;
    logic       busy;
    logic       done;

    vram_fill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .cpu_plot   (cpu_plot),
        .cpu_pos    (cpu_pos),
        .cpu_colour (cpu_colour),
        .plot       (plot),
        .buf_pos    (buf_pos),
        .colour     (colour),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: list of pixels still owed, plus a pending done flag
    int      m_q[$];
    bit      m_done;
    bit      m_acc;
    int      m_colour;
    bit      e_plot;
    int      e_pos;
    int      e_colour;

    int      plot_log[$];
    int      done_cnt;
    int      done_pos;

    typedef struct {
        int x; int y; int w; int h; int col;
        int n; int first; int last;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_update();
        m_acc = 1'b0;
        if (reset) begin
            m_q.delete();
            m_done   = 1'b0;
            e_plot   = 1'b0;
            e_pos    = 0;
            e_colour = 0;
        end else begin
            e_plot = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_q.size() > 0) begin
                if (!cpu_plot) begin
                    e_plot   = 1'b1;
                    e_pos    = m_q.pop_front();
                    e_colour = m_colour;
                    if (m_q.size() == 0) m_done = 1'b1;
                end
            end else if (cmd_valid) begin
                for (int yy = int'(cmd_y); yy < int'(cmd_y) + int'(cmd_h) && yy < SCREEN_H; yy++)
                    for (int xx = int'(cmd_x); xx < int'(cmd_x) + int'(cmd_w) && xx < SCREEN_W; xx++)
                        m_q.push_back(yy * SCREEN_W + xx);
                m_colour = int'(cmd_colour);
                m_acc    = 1'b1;
                if (m_q.size() == 0) m_done = 1'b1;
            end
            if (cpu_plot) begin
                e_plot   = 1'b1;
                e_pos    = int'(cpu_pos);
                e_colour = int'(cpu_colour);
            end
        end
    endtask

    task automatic check_outputs();
        bit e_busy;
        e_busy = m_done || (m_q.size() > 0);
        chk("plot", 32'(plot), 32'(e_plot));
        if (e_plot) begin
            chk("buf_pos", 32'(buf_pos), 32'(e_pos));
            chk("colour", 32'(colour), 32'(e_colour));
        end
        if (reset) begin
            chk("buf_pos_rst", 32'(buf_pos), 32'd0);
            chk("colour_rst", 32'(colour), 32'd0);
        end
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cmd_ready", 32'(cmd_ready), 32'(!e_busy));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        if (plot) plot_log.push_back(int'(buf_pos));
        if (done) begin
            done_cnt++;
            done_pos = int'(buf_pos);
        end
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int col);
        cmd_x      = 8'(x);
        cmd_y      = 7'(y);
        cmd_w      = 8'(w);
        cmd_h      = 7'(h);
        cmd_colour = 12'(col);
        cmd_valid  = 1'b1;
    endtask

    // issue one command and wait for its done, with bounded waits
    task automatic run_fill(input int x, input int y, input int w, input int h, input int col);
        int k;
        plot_log.delete();
        done_cnt = 0;
        drive_cmd(x, y, w, h, col);
        k = 0;
        do begin
            step_cycle();
            k++;
        end while (!m_acc && k < 20);
        cmd_valid = 1'b0;
        chk("accept_timeout", 32'(m_acc), 32'd1);
        k = 0;
        while (done_cnt == 0 && k < 500) begin
            step_cycle();
            k++;
        end
        chk("done_timeout", 32'(done_cnt), 32'd1);
        step_cycle();
    endtask

    initial begin
        int k;
        int acc_cnt;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_x      = 8'd0;
        cmd_y      = 7'd0;
        cmd_w      = 8'd0;
        cmd_h      = 7'd0;
        cmd_colour = 12'd0;
        cpu_plot   = 1'b0;
        cpu_pos    = 16'd0;
        cpu_colour = 12'd0;
        m_done     = 1'b0;
        e_plot     = 1'b0;
        done_cnt   = 0;
        done_pos   = 0;

        vecs[0] = '{x:2,   y:3,   w:3,   h:2,  col:'hF00, n:6,   first:482,   last:644};
        vecs[1] = '{x:158, y:118, w:10,  h:10, col:'h00F, n:4,   first:19038, last:19199};
        vecs[2] = '{x:5,   y:5,   w:0,   h:3,  col:'h123, n:0,   first:0,     last:0};
        vecs[3] = '{x:200, y:0,   w:4,   h:4,  col:'h456, n:0,   first:0,     last:0};
        vecs[4] = '{x:0,   y:119, w:4,   h:1,  col:'h0FF, n:4,   first:19040, last:19043};
        vecs[5] = '{x:159, y:0,   w:1,   h:1,  col:'hABC, n:1,   first:159,   last:159};
        vecs[6] = '{x:0,   y:0,   w:160, h:2,  col:'h777, n:320, first:0,     last:319};
        vecs[7] = '{x:10,  y:117, w:1,   h:10, col:'h321, n:3,   first:18730, last:19050};

        #1;
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_buf_pos", 32'(buf_pos), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        step_cycle();
        step_cycle();
        reset = 1'b0;
        step_cycle();

        // table-driven fills, no CPU traffic
        for (int i = 0; i < 8; i++) begin
            run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].col);
            chk($sformatf("vec%0d_count", i), 32'(plot_log.size()), 32'(vecs[i].n));
            if (plot_log.size() == vecs[i].n && vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first", i), 32'(plot_log[0]), 32'(vecs[i].first));
                chk($sformatf("vec%0d_last", i), 32'(plot_log[vecs[i].n-1]), 32'(vecs[i].last));
                chk($sformatf("vec%0d_done_pos", i), 32'(done_pos), 32'(vecs[i].last));
            end
        end

        // CPU steals the second fill cycle
        plot_log.delete();
        done_cnt = 0;
        drive_cmd(0, 0, 4, 1, 'hABC);
        step_cycle();
        cmd_valid = 1'b0;
        chk("steal_accept", 32'(m_acc), 32'd1);
        step_cycle();
        cpu_plot   = 1'b1;
        cpu_pos    = 16'd5000;
        cpu_colour = 12'h0F0;
        step_cycle();
        cpu_plot   = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 20) begin
            step_cycle();
            k++;
        end
        chk("steal_count", 32'(plot_log.size()), 32'd5);
        if (plot_log.size() == 5) begin
            chk("steal_p0", 32'(plot_log[0]), 32'd0);
            chk("steal_p1", 32'(plot_log[1]), 32'd5000);
            chk("steal_p2", 32'(plot_log[2]), 32'd1);
            chk("steal_p4", 32'(plot_log[4]), 32'd3);
        end
        chk("steal_done_pos", 32'(done_pos), 32'd3);
        step_cycle();

        // reset in the middle of a 100-pixel fill
        plot_log.delete();
        done_cnt = 0;
        drive_cmd(0, 10, 100, 1, 'h5A5);
        step_cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 30; i++) step_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step_cycle();
        reset = 1'b0;
        step_cycle();
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        run_fill(1, 1, 2, 2, 'h9C3);
        chk("after_rst_count", 32'(plot_log.size()), 32'd4);
        if (plot_log.size() == 4) begin
            chk("after_rst_p0", 32'(plot_log[0]), 32'd161);
            chk("after_rst_p3", 32'(plot_log[3]), 32'd322);
        end

        // cmd_valid held with changing fields while busy
        plot_log.delete();
        done_cnt = 0;
        acc_cnt  = 0;
        drive_cmd(20, 20, 5, 2, 'h555);
        k = 0;
        while (acc_cnt < 2 && k < 60) begin
            step_cycle();
            if (m_acc) begin
                acc_cnt++;
                drive_cmd(30, 30, 3, 1, 'h777);
            end
            k++;
        end
        cmd_valid = 1'b0;
        chk("hold_accepts", 32'(acc_cnt), 32'd2);
        k = 0;
        while (done_cnt < 2 && k < 40) begin
            step_cycle();
            k++;
        end
        chk("hold_dones", 32'(done_cnt), 32'd2);
        chk("hold_count", 32'(plot_log.size()), 32'd13);
        if (plot_log.size() == 13) begin
            chk("hold_first", 32'(plot_log[0]), 32'd3220);
            chk("hold_p9", 32'(plot_log[9]), 32'd3384);
            chk("hold_p10", 32'(plot_log[10]), 32'd4830);
        end
        step_cycle();

        // randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_x      = 8'($urandom_range(0, 170));
            cmd_y      = 7'($urandom_range(0, 125));
            cmd_w      = 8'($urandom_range(0, 12));
            cmd_h      = 7'($urandom_range(0, 6));
            cmd_colour = 12'($urandom);
            cpu_plot   = ($urandom_range(0, 3) == 0);
            cpu_pos    = 16'($urandom);
            cpu_colour = 12'($urandom);
            reset      = ($urandom_range(0, 299) == 0);
            step_cycle();
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cpu_plot  = 1'b0;
        step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
